short_stack_unit: RTL

- Per-ray short-stack manager directly downstream of the leaf list stage.
- Consumes leaf-miss reports (rayID, t_max_leaf) and pops the ray's deferred far-child node to traversal; when the stack is empty it either restarts the ray at the root or retires it as a terminal miss.
- Also accepts far-child pushes from traversal and per-ray scene-exit initialisation from the ray issue stage.

---
 rtl/short_stack_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/short_stack_unit.sv
// short_stack_unit: per-ray circular short stack feeding traversal with deferred far children.
// Define SS_STATS_EN to enable the restart/overflow/pop statistic counters.

module ss_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         stall,
    output logic         valid,
    output logic [W-1:0] rdata,
    output logic [1:0]   count
);
    logic [W-1:0] mem_q [2];
    logic         wp_q, wp_d, rp_q, rp_d, rd;
    logic [1:0]   cnt_q, cnt_d;

    assign valid = cnt_q != 2'd0;
    assign rdata = mem_q[rp_q];
    assign count = cnt_q;

    always_comb begin
        rd    = valid & ~stall;
        wp_d  = wp_q ^ wr;
        rp_d  = rp_q ^ rd;
        cnt_d = cnt_q + {1'b0, wr} - {1'b0, rd};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp_q  <= 1'b0;
            rp_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk)
        if (wr) mem_q[wp_q] <= wdata;
endmodule

module short_stack_unit #(
    parameter int NUM_RAYS    = 512,
    parameter int STACK_DEPTH = 4,
    parameter int NODEID_W    = 16,
    localparam int RW = $clog2(NUM_RAYS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ray_init_valid,
    input  logic [RW+31:0]         ray_init_data,
    input  logic                   trav_to_ss_valid,
    input  logic [RW+NODEID_W+31:0] trav_to_ss_data,
    output logic                   trav_to_ss_stall,
    input  logic                   list_to_ss_valid,
    input  logic [RW+31:0]         list_to_ss_data,
    output logic                   list_to_ss_stall,
    output logic                   ss_to_trav_valid,
    output logic [RW+NODEID_W+64:0] ss_to_trav_data,
    input  logic                   ss_to_trav_stall,
    output logic                   ss_to_shade_valid,
    output logic [RW-1:0]          ss_to_shade_data,
    input  logic                   ss_to_shade_stall,
    output logic [31:0]            stat_restarts,
    output logic [31:0]            stat_overflows,
    output logic [31:0]            stat_pops
);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic [PW-1:0]          top_q [NUM_RAYS];
    logic [CW-1:0]          cnt_q [NUM_RAYS];
    logic [NODEID_W+31:0]   stack_mem [NUM_RAYS*STACK_DEPTH];
    logic [31:0]            ts_mem [NUM_RAYS];
    logic [NODEID_W+31:0]   stack_rd_q;
    logic [31:0]            ts_rd_q;

    logic                   rr_q, rr_d;
    logic                   s2_v_q, s2_v_d, s2_hit_q, s2_hit_d;
    logic [RW-1:0]          s2_ray_q, s2_ray_d;
    logic [31:0]            s2_tleaf_q, s2_tleaf_d;

    logic                   init_go, pop_can, push_go, pop_go, st_we, credit_ok;
    logic [RW-1:0]          init_ray, push_ray, pop_ray, st_ray;
    logic [PW-1:0]          cur_top, top_d;
    logic [CW-1:0]          cur_cnt, cnt_d;
    logic [1:0]             trav_cnt, shade_cnt, trav_occ, shade_occ;
    logic                   miss, trav_wr, shade_wr;
    logic [RW+NODEID_W+64:0] trav_wdata;

    always_comb begin
        init_ray  = ray_init_data[RW+31:32];
        push_ray  = trav_to_ss_data[RW+NODEID_W+31:NODEID_W+32];
        pop_ray   = list_to_ss_data[RW+31:32];
        // Occupancy each output would reach if this cycle's pop is accepted, net of draining.
        trav_occ  = trav_cnt - {1'b0, ss_to_trav_valid & ~ss_to_trav_stall} + {1'b0, s2_v_q};
        shade_occ = shade_cnt - {1'b0, ss_to_shade_valid & ~ss_to_shade_stall} + {1'b0, s2_v_q};
        credit_ok = trav_occ < 2'd2 && shade_occ < 2'd2;
        init_go   = ray_init_valid;
        pop_can   = list_to_ss_valid & credit_ok & ~init_go;
        push_go   = trav_to_ss_valid & ~init_go & (~pop_can | rr_q);
        pop_go    = pop_can & (~trav_to_ss_valid | ~rr_q);
        rr_d      = rr_q ^ (pop_can & trav_to_ss_valid);
        trav_to_ss_stall = trav_to_ss_valid & ~push_go;
        list_to_ss_stall = list_to_ss_valid & ~pop_go;
        st_ray    = init_go ? init_ray : push_go ? push_ray : pop_ray;
        st_we     = init_go | push_go | pop_go;
        cur_top   = top_q[st_ray];
        cur_cnt   = cnt_q[st_ray];
        top_d     = push_go ? cur_top + PW'(1) : (pop_go && cur_cnt != '0) ? cur_top - PW'(1) : cur_top;
        cnt_d     = init_go ? '0 :
                    push_go ? (cur_cnt == CW'(STACK_DEPTH) ? cur_cnt : cur_cnt + CW'(1)) :
                    cur_cnt - CW'(cur_cnt != '0);
        s2_v_d     = pop_go;
        s2_ray_d   = pop_ray;
        s2_tleaf_d = list_to_ss_data[31:0];
        s2_hit_d   = cur_cnt != '0;
        miss       = ~s2_hit_q & (s2_tleaf_q >= ts_rd_q);
        trav_wr    = s2_v_q & ~miss;
        shade_wr   = s2_v_q & miss;
        trav_wdata = s2_hit_q ? {s2_ray_q, stack_rd_q[NODEID_W+31:32], s2_tleaf_q, stack_rd_q[31:0], 1'b0}
                              : {s2_ray_q, NODEID_W'(0), s2_tleaf_q, ts_rd_q, 1'b1};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_RAYS; i++) begin
                top_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            rr_q       <= 1'b0;
            s2_v_q     <= 1'b0;
            s2_hit_q   <= 1'b0;
            s2_ray_q   <= '0;
            s2_tleaf_q <= '0;
        end else begin
            if (st_we) begin
                top_q[st_ray] <= top_d;
                cnt_q[st_ray] <= cnt_d;
            end
            rr_q       <= rr_d;
            s2_v_q     <= s2_v_d;
            s2_hit_q   <= s2_hit_d;
            s2_ray_q   <= s2_ray_d;
            s2_tleaf_q <= s2_tleaf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (init_go) ts_mem[init_ray] <= ray_init_data[31:0];
        if (push_go) stack_mem[{push_ray, top_d}] <= trav_to_ss_data[NODEID_W+31:0];
        if (pop_go) begin
            stack_rd_q <= stack_mem[{pop_ray, cur_top}];
            ts_rd_q    <= ts_mem[pop_ray];
        end
    end

    ss_fifo2 #(.W(RW+NODEID_W+65)) u_trav_fifo (
        .clk(clk), .rst(rst), .wr(trav_wr), .wdata(trav_wdata), .stall(ss_to_trav_stall),
        .valid(ss_to_trav_valid), .rdata(ss_to_trav_data), .count(trav_cnt)
    );

    ss_fifo2 #(.W(RW)) u_shade_fifo (
        .clk(clk), .rst(rst), .wr(shade_wr), .wdata(s2_ray_q), .stall(ss_to_shade_stall),
        .valid(ss_to_shade_valid), .rdata(ss_to_shade_data), .count(shade_cnt)
    );

`ifdef SS_STATS_EN
    logic [31:0] restarts_q, restarts_d, overflows_q, overflows_d, pops_q, pops_d;

    always_comb begin
        restarts_d  = restarts_q + 32'(trav_wr & ~s2_hit_q);
        overflows_d = overflows_q + 32'(push_go && cur_cnt == CW'(STACK_DEPTH));
        pops_d      = pops_q + 32'(s2_v_q & s2_hit_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            restarts_q  <= '0;
            overflows_q <= '0;
            pops_q      <= '0;
        end else begin
            restarts_q  <= restarts_d;
            overflows_q <= overflows_d;
            pops_q      <= pops_d;
        end
    end

    assign stat_restarts  = restarts_q;
    assign stat_overflows = overflows_q;
    assign stat_pops      = pops_q;
`else
    assign stat_restarts  = '0;
    assign stat_overflows = '0;
    assign stat_pops      = '0;
`endif
endmodule
